// File: rtl/qkd_sift_core.sv
// BB84 sifting engine: drops basis mismatches, sacrifices every CHECK_EVERY-th
// matched event for QBER estimation and shifts the remaining Bob bits into the key.
module qkd_sift_core #(
    parameter int KEY_WIDTH   = 128,
    parameter int CHECK_EVERY = 4,
    parameter int ERR_THRESH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 photon_valid,
    output logic                 photon_ready,
    input  logic                 alice_bit,
    input  logic                 alice_basis,
    input  logic                 bob_basis,
    input  logic                 bob_bit,
    output logic [KEY_WIDTH-1:0] final_key,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 abort,
    output logic [15:0]          err_count,
    output logic [15:0]          discard_count,
    output logic [15:0]          key_bits
);

    localparam int SW = (CHECK_EVERY > 2) ? $clog2(CHECK_EVERY) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHECK_EVERY - 1);
    localparam logic [15:0]   KEY_LAST  = 16'(KEY_WIDTH - 1);
    localparam logic [15:0]   ERR_LAST  = 16'(ERR_THRESH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_ABORT   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [KEY_WIDTH-1:0]   r_key;
    logic                   r_key_valid;
    logic                   r_abort;
    logic [15:0]            r_err_count;
    logic [15:0]            r_discard_count;
    logic [15:0]            r_key_bits;
    logic [SW-1:0]          r_slot;

    logic w_accept;
    logic w_match;
    logic w_check_slot;
    logic w_bit_err;

    assign w_accept     = photon_valid && (r_state == ST_COLLECT);
    assign w_match      = (alice_basis == bob_basis);
    assign w_check_slot = (r_slot == LAST_SLOT);
    assign w_bit_err    = (alice_bit != bob_bit);

    // Control FSM, sifting counters and key shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_key           <= '0;
            r_key_valid     <= 1'b0;
            r_abort         <= 1'b0;
            r_err_count     <= 16'd0;
            r_discard_count <= 16'd0;
            r_key_bits      <= 16'd0;
            r_slot          <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        if (!w_match) begin
                            if (r_discard_count != 16'hFFFF) begin
                                r_discard_count <= r_discard_count + 16'd1;
                            end
                        end else if (w_check_slot) begin
                            r_slot <= '0;
                            if (w_bit_err) begin
                                r_err_count <= r_err_count + 16'd1;
                                if (r_err_count == ERR_LAST) begin
                                    r_state <= ST_ABORT;
                                    r_key   <= '0;
                                    r_abort <= 1'b1;
                                end
                            end
                        end else begin
                            // Key slot: only Bob's measurement matters here.
                            r_slot     <= r_slot + SW'(1);
                            r_key      <= {r_key[KEY_WIDTH-2:0], bob_bit};
                            r_key_bits <= r_key_bits + 16'd1;
                            if (r_key_bits == KEY_LAST) begin
                                r_state     <= ST_DONE;
                                r_key_valid <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE, DONE and ABORT all restart a fresh run on start.
                    if (start) begin
                        r_state         <= ST_COLLECT;
                        r_key           <= '0;
                        r_key_valid     <= 1'b0;
                        r_abort         <= 1'b0;
                        r_err_count     <= 16'd0;
                        r_discard_count <= 16'd0;
                        r_key_bits      <= 16'd0;
                        r_slot          <= '0;
                    end
                end
            endcase
        end
    end

    assign photon_ready  = (r_state == ST_COLLECT);
    assign busy          = (r_state == ST_COLLECT);
    assign final_key     = r_key;
    assign key_valid     = r_key_valid;
    assign abort         = r_abort;
    assign err_count     = r_err_count;
    assign discard_count = r_discard_count;
    assign key_bits      = r_key_bits;

endmodule

// File: tb/tb_qkd_sift_core.sv
// Directed bench for qkd_sift_core with KEY_WIDTH=8, CHECK_EVERY=4, ERR_THRESH=2.
module tb_qkd_sift_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic        photon_valid;
    logic        photon_ready;
    logic        alice_bit;
    logic        alice_basis;
    logic        bob_basis;
    logic        bob_bit;
    logic [7:0]  final_key;
    logic        key_valid;
    logic        busy;
    logic        abort;
    logic [15:0] err_count;
    logic [15:0] discard_count;
    logic [15:0] key_bits;

    int n_cmp;
    int n_bad;

    // Bob bits for events 1..10 (MSB = event 1): 1,0,1,x,1,0,0,x,1,1 with x = 0.
    localparam logic [9:0] BOB_V      = 10'b1010100011;
    localparam logic [9:0] FLIP_NONE  = 10'b0000000000;
    localparam logic [9:0] FLIP_CHECK = 10'b0001000100;
    localparam logic [9:0] FLIP_KEY   = 10'b1110111011;

    qkd_sift_core #(.KEY_WIDTH(8), .CHECK_EVERY(4), .ERR_THRESH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .photon_valid  (photon_valid),
        .photon_ready  (photon_ready),
        .alice_bit     (alice_bit),
        .alice_basis   (alice_basis),
        .bob_basis     (bob_basis),
        .bob_bit       (bob_bit),
        .final_key     (final_key),
        .key_valid     (key_valid),
        .busy          (busy),
        .abort         (abort),
        .err_count     (err_count),
        .discard_count (discard_count),
        .key_bits      (key_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic ab, input logic aba, input logic bba, input logic bb);
        @(negedge clk);
        photon_valid = 1'b1;
        alice_bit    = ab;
        alice_basis  = aba;
        bob_basis    = bba;
        bob_bit      = bb;
        @(posedge clk);
        #1;
        photon_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Events first..last (1-based); optional basis-mismatched decoy before each.
    task automatic run_seq(input logic [9:0] flip, input bit decoy, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (decoy) send(~BOB_V[10-i], 1'b0, 1'b1, ~BOB_V[10-i]);
            send(BOB_V[10-i] ^ flip[10-i], 1'b1, 1'b1, BOB_V[10-i]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; start = 1'b0; photon_valid = 1'b0;
        alice_bit = 1'b0; alice_basis = 1'b0; bob_basis = 1'b0; bob_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key", final_key, 8'h00);
        chk("rst_ready", photon_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // An event offered in IDLE must be ignored.
        send(1'b1, 1'b0, 1'b0, 1'b1);
        chk("idle_ignore", key_bits, 16'd0);

        // Scenario 1: clean run.
        pulse_start();
        chk("s1_ready", photon_ready, 1'b1);
        run_seq(FLIP_NONE, 1'b0, 1, 9);
        chk("s1_bits9", key_bits, 16'd7);
        chk("s1_kv9", key_valid, 1'b0);
        run_seq(FLIP_NONE, 1'b0, 10, 10);
        chk("s1_kv", key_valid, 1'b1);
        chk("s1_key", final_key, 8'hB3);
        chk("s1_err", err_count, 16'd0);
        chk("s1_bits", key_bits, 16'd8);
        chk("s1_ready_done", photon_ready, 1'b0);

        // Scenario 2: decoys before every matched event.
        pulse_start();
        run_seq(FLIP_NONE, 1'b1, 1, 10);
        chk("s2_key", final_key, 8'hB3);
        chk("s2_disc", discard_count, 16'd10);
        chk("s2_kv", key_valid, 1'b1);

        // Scenario 3: check-slot errors reach the abort threshold.
        pulse_start();
        run_seq(FLIP_CHECK, 1'b0, 1, 4);
        chk("s3_err1", err_count, 16'd1);
        chk("s3_noabort", abort, 1'b0);
        run_seq(FLIP_CHECK, 1'b0, 5, 8);
        chk("s3_abort", abort, 1'b1);
        chk("s3_key0", final_key, 8'h00);
        chk("s3_kv", key_valid, 1'b0);
        chk("s3_err2", err_count, 16'd2);
        chk("s3_busy", busy, 1'b0);
        run_seq(FLIP_CHECK, 1'b0, 9, 10);
        chk("s3_held", key_bits, 16'd6);

        // Scenario 4: key slots disagree, check slots clean.
        pulse_start();
        run_seq(FLIP_KEY, 1'b0, 1, 10);
        chk("s4_err", err_count, 16'd0);
        chk("s4_key", final_key, 8'hB3);
        chk("s4_kv", key_valid, 1'b1);

        // Scenario 5: asynchronous reset mid-collect.
        pulse_start();
        run_seq(FLIP_NONE, 1'b0, 1, 5);
        chk("s5_pre_bits", key_bits, 16'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_key", final_key, 8'h00);
        chk("s5_bits", key_bits, 16'd0);
        chk("s5_ready", photon_ready, 1'b0);
        chk("s5_busy", busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        run_seq(FLIP_NONE, 1'b0, 1, 10);
        chk("s5_key_after", final_key, 8'hB3);

        // Scenario 6: start in COLLECT is ignored; start in DONE restarts.
        pulse_start();
        run_seq(FLIP_NONE, 1'b0, 1, 2);
        pulse_start();
        chk("s6_bits_kept", key_bits, 16'd2);
        chk("s6_busy", busy, 1'b1);
        run_seq(FLIP_NONE, 1'b0, 3, 10);
        chk("s6_key", final_key, 8'hB3);
        pulse_start();
        chk("s6_kv_drop", key_valid, 1'b0);
        chk("s6_bits0", key_bits, 16'd0);
        chk("s6_key0", final_key, 8'h00);
        chk("s6_ready", photon_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
